// File: rtl/udp_tx_seq_if.sv
// udp_tx_seq_if: FIFO-fill / UDP-transmit handshake bundle.
// master = sequencer, slave = fifo_write + fifod2mac side.
interface udp_tx_seq_if #(
  parameter int LEN_W = 16
);
  logic             fs_fw;
  logic             fd_fw;
  logic             fs_udp_tx;
  logic             fd_udp_tx;
  logic [LEN_W-1:0] eth_tx_len;
  logic [7:0]       fifo_part;

  modport master (
    output fs_fw,
    output fs_udp_tx,
    output eth_tx_len,
    output fifo_part,
    input  fd_fw,
    input  fd_udp_tx
  );

  modport slave (
    input  fs_fw,
    input  fs_udp_tx,
    input  eth_tx_len,
    input  fifo_part,
    output fd_fw,
    output fd_udp_tx
  );
endinterface

// File: rtl/udp_tx_seq.sv
// udp_tx_seq: single/burst/continuous frame sequencer driving the
// FIFO-fill then UDP-transmit handshakes, with channel rotation,
// inter-frame gap, handshake timeout and frame/error counters.
// Ports: sys_clk, rst (async, active-high); trig_i, mode_i,
// burst_num_i, gap_cycles_i, data_len_i (control); hs (handshake
// master: fs_fw/fd_fw, fs_udp_tx/fd_udp_tx, eth_tx_len, fifo_part);
// busy_o, err_o, frame_cnt_o, state_dbg_o (status).
module udp_tx_seq #(
  parameter int         NCH       = 4,
  parameter logic [7:0] PART_BASE = 8'h0D,
  parameter int         LEN_W     = 16,
  parameter int         CNT_W     = 16,
  parameter int         TO_W      = 24
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             trig_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] burst_num_i,
  input  logic [CNT_W-1:0] gap_cycles_i,
  input  logic [LEN_W-1:0] data_len_i,
  udp_tx_seq_if.master     hs,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [7:0]       state_dbg_o
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic             unlim_q, unlim_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       part_q, part_d;
  logic             fdt_meta_q, fdt_q;

  logic to_hit;
  logic gap_ok;
  logic more;

  // fd_udp_tx comes from the gmii_txc domain
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      fdt_meta_q <= 1'b0;
      fdt_q      <= 1'b0;
    end else begin
      fdt_meta_q <= hs.fd_udp_tx;
      fdt_q      <= fdt_meta_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      budget_q <= '0;
      unlim_q  <= 1'b0;
      gap_q    <= '0;
      fcnt_q   <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      len_q    <= '0;
      part_q   <= PART_BASE;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      budget_q <= budget_d;
      unlim_q  <= unlim_d;
      gap_q    <= gap_d;
      fcnt_q   <= fcnt_d;
      to_q     <= to_d;
      err_q    <= err_d;
      len_q    <= len_d;
      part_q   <= part_d;
    end
  end

  assign to_hit = &to_q;
  assign gap_ok = (gap_q >= gap_cycles_i);
  // mode 2 keeps going while the key is held
  assign more   = unlim_q ? trig_i : (budget_q != '0);

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    budget_d = budget_q;
    unlim_d  = unlim_q;
    gap_d    = gap_q;
    fcnt_d   = fcnt_q;
    err_d    = err_q;
    len_d    = len_q;
    part_d   = part_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig_i) begin
          state_d  = S_LOAD;
          unlim_d  = (mode_i == 2'd2);
          budget_d = CNT_W'(1);
          if (mode_i == 2'd1 && burst_num_i != '0)
            budget_d = burst_num_i;
        end
      end
      S_LOAD: begin
        len_d  = data_len_i;
        part_d = PART_BASE + 8'(ch_q);
        if (data_len_i == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // done beats a coincident timeout
        if (hs.fd_fw) begin
          state_d = S_SEND;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_SEND: begin
        if (fdt_q) begin
          fcnt_d   = fcnt_q + CNT_W'(1);
          ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
          budget_d = budget_q - CNT_W'(1);
          gap_d    = '0;
          state_d  = S_GAP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_GAP: begin
        if (!gap_ok)
          gap_d = gap_q + CNT_W'(1);
        // never restart before both dones have dropped
        if (gap_ok && !hs.fd_fw && !fdt_q)
          state_d = more ? S_LOAD : S_DONE;
      end
      S_DONE: begin
        if (!trig_i)
          state_d = S_IDLE;
      end
      S_FAULT: begin
        if (!trig_i && !hs.fd_fw && !fdt_q)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // timeout counter restarts on every state entry
  always_comb begin
    to_d = '0;
    if (state_d == state_q &&
        (state_q == S_FILL || state_q == S_SEND))
      to_d = to_q + TO_W'(1);
  end

  assign hs.fs_fw      = (state_q == S_FILL);
  assign hs.fs_udp_tx  = (state_q == S_SEND);
  assign hs.eth_tx_len = len_q;
  assign hs.fifo_part  = part_q;

  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign frame_cnt_o = fcnt_q;
  assign state_dbg_o = 8'(state_q);

endmodule
